tb_console_mon: RTL and testbench
=================================

TB_CONSOLE_MON -- requirements
Module: tb_console_mon

Interface
REQ-001 SHALL have parameter DATA_W, default 128, AXI write-data width (64/128/256).
REQ-002 SHALL have parameter CONSOLE_ADDR, default 32'h01ff_fff0, console byte-sink address.
REQ-003 SHALL have parameters PASS_VAL 64'h444333222, FAIL_VAL 64'h2382348720, exit magic values.
REQ-004 SHALL have parameter NUM_WB, default 2, number of monitored writeback ports.
REQ-005 SHALL have parameters FIFO_DEPTH 16 (power of 2) and MAX_CYCLES 32'h3000000 (timeout).
REQ-006 SHALL have one clock and an asynchronous active-low reset: i_pad_clk in 1, rising-edge clock; i_pad_rst_b in 1, async active-low reset.
REQ-007 Ports awvalid/awready in 1 each, awaddr in 32, awlen in 4: AW channel, snooped only.
REQ-008 Ports wvalid/wready/wlast in 1 each, wdata in DATA_W, wstrb in DATA_W/8: W channel, snooped only.
REQ-009 Ports wb_vld in NUM_WB, wb_data in 64*NUM_WB: per-pipe writeback value.
REQ-010 Ports char_valid out 1, char_data out 8, char_ready in 1: console character stream.
REQ-011 Ports done out 1, exit_code out 2, cycle_cnt out 32, ovf out 1, bad_strb_cnt out 16: status.

Function
REQ-012 Snoop FSM states IDLE, HIT, MISS; IDLE->HIT on awvalid&awready with awaddr==CONSOLE_ADDR and awlen==0, else IDLE->MISS on AW handshake.
REQ-013 HIT/MISS->IDLE on W beat (wvalid&wready) with wlast; AW handshake while not IDLE ignored.
REQ-014 W beat accepted in HIT with wstrb having exactly one 4-bit-aligned nibble == 4'hf and all other bits 0 -> push wdata[32k+7:32k] (k = that word index).
REQ-015 Any other HIT strobe pattern -> no push, bad_strb_cnt +1, saturating at 16'hffff.
REQ-016 Push when FIFO full -> character dropped, ovf set sticky; no other effect.
REQ-017 char_valid = FIFO non-empty; pop on char_valid&char_ready; push+pop same cycle when full -> both occur, no overflow.
REQ-018 Push-to-char_valid latency 1 cycle (char_valid high the cycle after the accepting W beat).
REQ-019 wb_vld/wb_data registered one stage; compare on registered values; exit event 1 cycle after wb input.
REQ-020 Any valid registered port == PASS_VAL -> pass event; == FAIL_VAL -> fail event; both same cycle -> fail wins.
REQ-021 cycle_cnt increments every cycle while done==0, freezes when done==1.
REQ-022 cycle_cnt == MAX_CYCLES-1 with no other event -> timeout event; wb event same cycle takes priority.
REQ-023 First event sets done=1 and exit_code (01 pass, 10 fail, 11 timeout); both sticky until reset; later events ignored.
REQ-024 Console snooping and FIFO continue after done.

Reset
REQ-025 On i_pad_rst_b low: FSM IDLE, FIFO empty, char_valid 0, char_data 0, done 0, exit_code 00, cycle_cnt 0, ovf 0, bad_strb_cnt 0, wb stage cleared.
REQ-026 Reset asserted mid-transaction discards partial AW/W state; after release FSM waits for fresh AW handshake.

Structure
REQ-027 Package tb_mon_pkg SHALL hold exit-code constants (EXIT_NONE/PASS/FAIL/TIMEOUT) and FSM state typedef.
REQ-028 FIFO SHALL be sub-module tb_console_fifo (param WIDTH=8, DEPTH), pointers one bit wider than log2(DEPTH) for full/empty.

Verification
REQ-029 AW 0x01ff_fff0 len 0, W wstrb 16'h00f0, wdata[39:32]=0x41 -> char 'A' valid next cycle.
REQ-030 AW 0x01ff_fff0, wstrb 16'h00ff -> no char, bad_strb_cnt=1; AW 0x0000_1000 any strobe -> nothing.
REQ-031 17 console writes, char_ready=0 -> 16 chars held, ovf=1; drain yields first 16 in order.
REQ-032 wb_data port0=PASS_VAL, port1=FAIL_VAL same cycle -> done=1, exit_code=10 one cycle later.
REQ-033 MAX_CYCLES=100, no wb events -> done=1, exit_code=11, cycle_cnt frozen at 99.
REQ-034 Reset pulse between AW hit and its W beat -> W beat after reset produces no char.

Source files
------------

// File: rtl/tb_mon_pkg.sv
// Shared constants and types for the simulation console / exit monitor.
package tb_mon_pkg;

    localparam logic [1:0] EXIT_NONE    = 2'b00;
    localparam logic [1:0] EXIT_PASS    = 2'b01;
    localparam logic [1:0] EXIT_FAIL    = 2'b10;
    localparam logic [1:0] EXIT_TIMEOUT = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIT  = 2'd1,
        ST_MISS = 2'd2
    } snoop_state_t;

endpackage

// File: rtl/tb_console_fifo.sv
// Small character FIFO; pointers carry one extra wrap bit to tell full from empty.
module tb_console_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             empty,
    output logic             ovf_pulse
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign do_pop    = pop && !empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign do_push   = push && (!full || do_pop);
    assign ovf_pulse = push && full && !do_pop;
    assign pop_data  = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
            if (do_pop)  rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/tb_console_mon.sv
// Snoops AXI writes to a console byte sink and watches writeback ports for exit magic values.
module tb_console_mon
    import tb_mon_pkg::*;
#(
    parameter int          DATA_W       = 128,
    parameter logic [31:0] CONSOLE_ADDR = 32'h01ff_fff0,
    parameter logic [63:0] PASS_VAL     = 64'h444333222,
    parameter logic [63:0] FAIL_VAL     = 64'h2382348720,
    parameter int          NUM_WB       = 2,
    parameter int          FIFO_DEPTH   = 16,
    parameter logic [31:0] MAX_CYCLES   = 32'h3000000
) (
    input  logic                  i_pad_clk,
    input  logic                  i_pad_rst_b,
    input  logic                  awvalid,
    input  logic                  awready,
    input  logic [31:0]           awaddr,
    input  logic [3:0]            awlen,
    input  logic                  wvalid,
    input  logic                  wready,
    input  logic                  wlast,
    input  logic [DATA_W-1:0]     wdata,
    input  logic [DATA_W/8-1:0]   wstrb,
    input  logic [NUM_WB-1:0]     wb_vld,
    input  logic [64*NUM_WB-1:0]  wb_data,
    output logic                  char_valid,
    output logic [7:0]            char_data,
    input  logic                  char_ready,
    output logic                  done,
    output logic [1:0]            exit_code,
    output logic [31:0]           cycle_cnt,
    output logic                  ovf,
    output logic [15:0]           bad_strb_cnt,
    output snoop_state_t          dbg_state
);

    // Handshakes: a beat transfers on any cycle where valid and ready are both high.
    localparam int STRB_W = DATA_W / 8;
    localparam int NW     = DATA_W / 32;

    snoop_state_t          state, state_nxt;
    logic                  aw_hs, w_hs;
    logic                  strb_ok;
    logic [7:0]            strb_byte;
    logic                  push, bad_beat, fifo_empty, ovf_pulse;
    logic [NUM_WB-1:0]     wb_vld_q;
    logic [64*NUM_WB-1:0]  wb_data_q;
    logic                  any_pass, any_fail, to_evt;
    logic                  unused_wdata;

    assign aw_hs        = awvalid && awready;
    assign w_hs         = wvalid && wready;
    assign dbg_state    = state;
    assign unused_wdata = ^wdata;

    always_ff @(posedge i_pad_clk or negedge i_pad_rst_b) begin
        if (!i_pad_rst_b) state <= ST_IDLE;
        else              state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (aw_hs) begin
                    if (awaddr == CONSOLE_ADDR && awlen == 4'd0) state_nxt = ST_HIT;
                    else                                         state_nxt = ST_MISS;
                end
            end
            ST_HIT, ST_MISS: begin
                if (w_hs && wlast) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // A console beat must enable exactly one full 32-bit word; its low byte is the character.
    always_comb begin
        strb_ok   = 1'b0;
        strb_byte = '0;
        for (int k = 0; k < NW; k++) begin
            if (wstrb == (STRB_W'(4'hf) << (4 * k))) begin
                strb_ok   = 1'b1;
                strb_byte = wdata[32*k +: 8];
            end
        end
    end

    assign push     = (state == ST_HIT) && w_hs && strb_ok;
    assign bad_beat = (state == ST_HIT) && w_hs && !strb_ok;

    tb_console_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (i_pad_clk),
        .rst_b     (i_pad_rst_b),
        .push      (push),
        .push_data (strb_byte),
        .pop       (char_ready),
        .pop_data  (char_data),
        .empty     (fifo_empty),
        .ovf_pulse (ovf_pulse)
    );

    assign char_valid = !fifo_empty;

    always_comb begin
        any_pass = 1'b0;
        any_fail = 1'b0;
        for (int i = 0; i < NUM_WB; i++) begin
            if (wb_vld_q[i] && wb_data_q[64*i +: 64] == PASS_VAL) any_pass = 1'b1;
            if (wb_vld_q[i] && wb_data_q[64*i +: 64] == FAIL_VAL) any_fail = 1'b1;
        end
    end

    assign to_evt = (cycle_cnt == MAX_CYCLES - 32'd1);

    always_ff @(posedge i_pad_clk or negedge i_pad_rst_b) begin
        if (!i_pad_rst_b) begin
            wb_vld_q     <= '0;
            wb_data_q    <= '0;
            done         <= 1'b0;
            exit_code    <= EXIT_NONE;
            cycle_cnt    <= '0;
            ovf          <= 1'b0;
            bad_strb_cnt <= '0;
        end else begin
            wb_vld_q  <= wb_vld;
            wb_data_q <= wb_data;
            if (ovf_pulse) ovf <= 1'b1;
            if (bad_beat && bad_strb_cnt != 16'hffff) bad_strb_cnt <= bad_strb_cnt + 16'd1;
            // The counter stops on the event cycle itself so it reports the cycle that ended the run.
            if (!done) begin
                if (any_fail) begin
                    done      <= 1'b1;
                    exit_code <= EXIT_FAIL;
                end else if (any_pass) begin
                    done      <= 1'b1;
                    exit_code <= EXIT_PASS;
                end else if (to_evt) begin
                    done      <= 1'b1;
                    exit_code <= EXIT_TIMEOUT;
                end else begin
                    cycle_cnt <= cycle_cnt + 32'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_tb_console_mon.sv
// Directed bench for tb_console_mon: console char scoreboard plus exit/timeout status checks.
module tb_tb_console_mon;
    import tb_mon_pkg::*;

    localparam int          DATA_W   = 128;
    localparam int          NUM_WB   = 2;
    localparam logic [31:0] CON_ADDR = 32'h01ff_fff0;
    localparam logic [63:0] P_VAL    = 64'h444333222;
    localparam logic [63:0] F_VAL    = 64'h2382348720;

    // clock / reset
    logic clk = 1'b0;
    logic rst_b, rst_t_b;
    always #5 clk = ~clk;

    logic                 awvalid, awready, wvalid, wready, wlast, char_ready;
    logic [31:0]          awaddr;
    logic [3:0]           awlen;
    logic [DATA_W-1:0]    wdata;
    logic [DATA_W/8-1:0]  wstrb;
    logic [NUM_WB-1:0]    wb_vld, wb_vld_to;
    logic [64*NUM_WB-1:0] wb_data;

    logic        char_valid, done, ovf;
    logic [7:0]  char_data;
    logic [1:0]  exit_code;
    logic [31:0] cycle_cnt;
    logic [15:0] bad_strb_cnt;
    snoop_state_t dbg_state;

    logic        to_char_valid, to_done, to_ovf;
    logic [7:0]  to_char_data;
    logic [1:0]  to_exit_code;
    logic [31:0] to_cycle_cnt;
    logic [15:0] to_bad_strb_cnt;
    snoop_state_t to_dbg_state;

    tb_console_mon #(.DATA_W(DATA_W), .NUM_WB(NUM_WB)) u_dut (
        .i_pad_clk(clk), .i_pad_rst_b(rst_b),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awlen(awlen),
        .wvalid(wvalid), .wready(wready), .wlast(wlast), .wdata(wdata), .wstrb(wstrb),
        .wb_vld(wb_vld), .wb_data(wb_data),
        .char_valid(char_valid), .char_data(char_data), .char_ready(char_ready),
        .done(done), .exit_code(exit_code), .cycle_cnt(cycle_cnt), .ovf(ovf),
        .bad_strb_cnt(bad_strb_cnt), .dbg_state(dbg_state)
    );

    tb_console_mon #(.DATA_W(DATA_W), .NUM_WB(NUM_WB), .MAX_CYCLES(32'd100)) u_to (
        .i_pad_clk(clk), .i_pad_rst_b(rst_t_b),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awlen(awlen),
        .wvalid(wvalid), .wready(wready), .wlast(wlast), .wdata(wdata), .wstrb(wstrb),
        .wb_vld(wb_vld_to), .wb_data(wb_data),
        .char_valid(to_char_valid), .char_data(to_char_data), .char_ready(char_ready),
        .done(to_done), .exit_code(to_exit_code), .cycle_cnt(to_cycle_cnt), .ovf(to_ovf),
        .bad_strb_cnt(to_bad_strb_cnt), .dbg_state(to_dbg_state)
    );

    // scoreboard
    logic [7:0] exp_q[$];
    logic [7:0] exp_c;
    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_b && char_valid && char_ready) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL char_unexpected: got %02h, expected none", char_data);
            end else begin
                exp_c = exp_q.pop_front();
                check("char_data", {56'd0, char_data}, {56'd0, exp_c});
            end
        end
    end

    // driver tasks
    function automatic logic [DATA_W-1:0] mk_data(input int k, input logic [7:0] b);
        logic [DATA_W-1:0] d;
        d = '0;
        d[32*k +: 8] = b;
        return d;
    endfunction

    function automatic logic [DATA_W/8-1:0] mk_strb(input int k);
        logic [DATA_W/8-1:0] s;
        s = '0;
        s[4*k +: 4] = 4'hf;
        return s;
    endfunction

    task automatic aw_beat(input logic [31:0] addr, input logic [3:0] len);
        awvalid = 1'b1; awready = 1'b1; awaddr = addr; awlen = len;
        @(posedge clk); #1;
        awvalid = 1'b0; awready = 1'b0;
    endtask

    task automatic w_beat(input logic [DATA_W-1:0] data, input logic [DATA_W/8-1:0] strb);
        wvalid = 1'b1; wready = 1'b1; wlast = 1'b1; wdata = data; wstrb = strb;
        @(posedge clk); #1;
        wvalid = 1'b0; wready = 1'b0; wlast = 1'b0;
    endtask

    task automatic console_write(input logic [31:0] addr, input logic [3:0] len,
                                 input logic [DATA_W-1:0] data, input logic [DATA_W/8-1:0] strb);
        aw_beat(addr, len);
        w_beat(data, strb);
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 60 && exp_q.size() != 0; i++) @(negedge clk);
        check(name, 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        awvalid = 0; awready = 0; awaddr = '0; awlen = '0;
        wvalid = 0; wready = 0; wlast = 0; wdata = '0; wstrb = '0;
        wb_vld = '0; wb_vld_to = '0; wb_data = '0; char_ready = 1'b1;
        rst_b = 1'b0; rst_t_b = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_b = 1'b1; rst_t_b = 1'b1;
        @(negedge clk);

        // reset state
        check("rst_char_valid", char_valid, 1'b0);
        check("rst_char_data", char_data, 8'h00);
        check("rst_done", done, 1'b0);
        check("rst_exit", exit_code, EXIT_NONE);
        check("rst_cycle_cnt", cycle_cnt, 32'd0);
        check("rst_ovf", ovf, 1'b0);
        check("rst_bad_strb", bad_strb_cnt, 16'd0);
        check("rst_state", dbg_state, ST_IDLE);

        // timeout instance: MAX_CYCLES=100, no writeback traffic
        for (int i = 0; i < 300 && !to_done; i++) @(negedge clk);
        check("to_done", to_done, 1'b1);
        check("to_exit", to_exit_code, EXIT_TIMEOUT);
        check("to_cycle_cnt", to_cycle_cnt, 32'd99);
        repeat (5) @(negedge clk);
        check("to_cycle_frozen", to_cycle_cnt, 32'd99);

        // single console char 'A' in word 1, valid the cycle after the W beat
        exp_q.push_back(8'h41);
        console_write(CON_ADDR, 4'd0, mk_data(1, 8'h41), 16'h00f0);
        @(negedge clk);
        check("a_latency_valid", char_valid, 1'b1);
        @(negedge clk);
        check("a_popped", char_valid, 1'b0);

        // other word lanes
        exp_q.push_back(8'h42);
        console_write(CON_ADDR, 4'd0, mk_data(0, 8'h42), 16'h000f);
        exp_q.push_back(8'h43);
        console_write(CON_ADDR, 4'd0, mk_data(3, 8'h43), 16'hf000);
        drain("lanes_drained");

        // bad strobes and non-console writes
        console_write(CON_ADDR, 4'd0, mk_data(1, 8'h44), 16'h00ff);
        @(negedge clk);
        check("bad_strb_nochar", char_valid, 1'b0);
        check("bad_strb_cnt1", bad_strb_cnt, 16'd1);
        console_write(32'h0000_1000, 4'd0, mk_data(1, 8'h45), 16'h00f0);
        @(negedge clk);
        check("miss_nochar", char_valid, 1'b0);
        check("miss_bad_cnt", bad_strb_cnt, 16'd1);
        console_write(CON_ADDR, 4'd1, mk_data(1, 8'h46), 16'h00f0);
        @(negedge clk);
        check("len1_nochar", char_valid, 1'b0);
        console_write(CON_ADDR, 4'd0, mk_data(1, 8'h47), 16'h0000);
        @(negedge clk);
        check("zero_strb_cnt2", bad_strb_cnt, 16'd2);
        check("pre_ovf", ovf, 1'b0);

        // overflow: 17 writes with the sink stalled
        @(posedge clk); #1 char_ready = 1'b0;
        for (int i = 0; i < 17; i++) begin
            if (i < 16) exp_q.push_back(8'h61 + 8'(i));
            console_write(CON_ADDR, 4'd0, mk_data(i % 4, 8'h61 + 8'(i)), mk_strb(i % 4));
        end
        @(negedge clk);
        check("ovf_set", ovf, 1'b1);
        check("ovf_held_valid", char_valid, 1'b1);
        check("ovf_head", char_data, 8'h61);
        @(posedge clk); #1 char_ready = 1'b1;
        drain("ovf_drained");
        @(negedge clk);
        check("ovf_17th_dropped", char_valid, 1'b0);

        // pass and fail on the same cycle: fail wins
        wb_vld = 2'b11;
        wb_data = {F_VAL, P_VAL};
        @(posedge clk); #1 wb_vld = 2'b00;
        @(posedge clk); #1;
        check("exit_done", done, 1'b1);
        check("exit_fail", exit_code, EXIT_FAIL);

        // later pass ignored
        wb_vld = 2'b01;
        wb_data = {64'd0, P_VAL};
        @(posedge clk); #1 wb_vld = 2'b00;
        repeat (2) @(posedge clk); #1;
        check("exit_sticky", exit_code, EXIT_FAIL);

        // console still live after done
        exp_q.push_back(8'h5a);
        console_write(CON_ADDR, 4'd0, mk_data(2, 8'h5a), 16'h0f00);
        drain("post_done_drained");

        // reset between AW hit and W beat
        aw_beat(CON_ADDR, 4'd0);
        rst_b = 1'b0;
        #2;
        check("rst_mid_state", dbg_state, ST_IDLE);
        @(posedge clk); #1 rst_b = 1'b1;
        w_beat(mk_data(1, 8'h51), 16'h00f0);
        @(negedge clk);
        check("rst_mid_nochar", char_valid, 1'b0);
        check("rst_mid_done", done, 1'b0);
        check("rst_mid_exit", exit_code, EXIT_NONE);
        check("rst_mid_ovf", ovf, 1'b0);
        repeat (3) @(negedge clk);
        check("final_queue_empty", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
